// File: rtl/cpu_reset_seq_if.sv
// Handshake bundle between the boot control register, the m68k core reset and the address decoder.
// The slave modport is the sequencer's view; the master modport is the boot-control/CPU side.
`ifndef MODE_RAM
`define MODE_RAM        2'd0
`define MODE_BOOTLOADER 2'd1
`define MODE_BOOTSTRAP  2'd2
`endif

interface cpu_reset_seq_if;
  logic       req_i;
  logic [1:0] mode_i;
  logic       cpu_cyc_i;
  logic       cpu_rst_o;
  logic [1:0] mode_o;
  logic       busy_o;
  logic       drain_to_o;
  logic [7:0] rst_count_o;

  modport slave (
    input  req_i, mode_i, cpu_cyc_i,
    output cpu_rst_o, mode_o, busy_o, drain_to_o, rst_count_o
  );

  modport master (
    output req_i, mode_i, cpu_cyc_i,
    input  cpu_rst_o, mode_o, busy_o, drain_to_o, rst_count_o
  );
endinterface

// File: rtl/cpu_reset_seq.sv
// m68k reset sequencer: drains the current bus cycle, stretches reset, and only lets the
// memory mode follow boot control while the core is held in reset.
`ifndef MODE_RAM
`define MODE_RAM        2'd0
`define MODE_BOOTLOADER 2'd1
`define MODE_BOOTSTRAP  2'd2
`endif

module cpu_reset_seq #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  cpu_reset_seq_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d;
  logic       drain_to_q, drain_to_d;
  logic [7:0] rst_count_q, rst_count_d;
  logic       cpu_rst_q, cpu_rst_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    drain_to_d  = drain_to_q;
    rst_count_d = rst_count_q;
    // Outputs lag the state register by one edge so mode updates line up with cpu_rst_o.
    cpu_rst_d   = (state_q == ST_HOLD) || (state_q == ST_SETTLE);
    busy_d      = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          state_d = bus.cpu_cyc_i ? ST_DRAIN : ST_HOLD;
          cnt_d   = 8'd0;
          if (rst_count_q != 8'hFF) rst_count_d = rst_count_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (!bus.cpu_cyc_i) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d    = ST_HOLD;
          cnt_d      = 8'd0;
          drain_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        mode_d = bus.mode_i;
        if (bus.req_i) begin
          cnt_d = 8'd0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (bus.req_i) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_HOLD;
      cnt_q       <= 8'd0;
      mode_q      <= `MODE_BOOTSTRAP;
      drain_to_q  <= 1'b0;
      rst_count_q <= 8'd0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      drain_to_q  <= drain_to_d;
      rst_count_q <= rst_count_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cpu_rst_o   = cpu_rst_q;
  assign bus.mode_o      = mode_q;
  assign bus.busy_o      = busy_q;
  assign bus.drain_to_o  = drain_to_q;
  assign bus.rst_count_o = rst_count_q;

endmodule

// File: tb/tb_cpu_reset_seq.sv
// Directed bench for cpu_reset_seq: power-up, idle/drain/timeout resets, retrigger,
// counter saturation and reset during drain.
`ifndef MODE_RAM
`define MODE_RAM        2'd0
`define MODE_BOOTLOADER 2'd1
`define MODE_BOOTSTRAP  2'd2
`endif

module tb_cpu_reset_seq;
  localparam int HOLD   = 16;
  localparam int SETTLE = 4;
  localparam int TO     = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_reset_seq_if bus_if ();

  cpu_reset_seq #(
    .HOLD_CYCLES  (HOLD),
    .SETTLE_CYCLES(SETTLE),
    .DRAIN_TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts high samples of cpu_rst_o (current one included) until it falls; also counts
  // high samples whose mode_o differs from exp_mode.
  task automatic wait_release(input logic [1:0] exp_mode, output int hi, output int mode_bad);
    hi = 0;
    mode_bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus_if.cpu_rst_o === 1'b1) begin
        hi++;
        if (bus_if.mode_o !== exp_mode) mode_bad++;
      end else if (hi > 0) begin
        break;
      end
      tick();
    end
  endtask

  initial begin
    int hi, hi2, mbad, lbad, n, bad;

    rst = 1'b1;
    bus_if.req_i     = 1'b0;
    bus_if.mode_i    = `MODE_BOOTLOADER;
    bus_if.cpu_cyc_i = 1'b0;

    // Power-up
    repeat (3) tick();
    check("por_cpu_rst", 32'(bus_if.cpu_rst_o), 32'd1);
    check("por_mode", 32'(bus_if.mode_o), 32'(`MODE_BOOTSTRAP));
    check("por_busy", 32'(bus_if.busy_o), 32'd1);
    check("por_count", 32'(bus_if.rst_count_o), 32'd0);
    check("por_drain_to", 32'(bus_if.drain_to_o), 32'd0);
    rst = 1'b0;
    tick();
    check("por_first_hold_mode", 32'(bus_if.mode_o), 32'(`MODE_BOOTLOADER));
    wait_release(`MODE_BOOTLOADER, hi, mbad);
    check("por_high_len", 32'(hi), 32'(HOLD + SETTLE));
    check("por_busy_after", 32'(bus_if.busy_o), 32'd0);
    check("por_count_after", 32'(bus_if.rst_count_o), 32'd0);

    // Idle soft reset with mode change in the request cycle
    bus_if.req_i  = 1'b1;
    bus_if.mode_i = `MODE_RAM;
    tick();
    bus_if.req_i = 1'b0;
    check("idle_rst_lag", 32'(bus_if.cpu_rst_o), 32'd0);
    check("idle_mode_frozen", 32'(bus_if.mode_o), 32'(`MODE_BOOTLOADER));
    check("idle_count", 32'(bus_if.rst_count_o), 32'd1);
    wait_release(`MODE_RAM, hi, mbad);
    check("idle_high_len", 32'(hi), 32'(HOLD + SETTLE));
    check("idle_mode_in_reset", 32'(mbad), 32'd0);
    bus_if.mode_i = `MODE_BOOTLOADER;
    repeat (3) tick();
    check("idle_mode_hold_after", 32'(bus_if.mode_o), 32'(`MODE_RAM));

    // Drain: bus cycle drops in time
    bus_if.mode_i    = `MODE_BOOTSTRAP;
    bus_if.cpu_cyc_i = 1'b1;
    bus_if.req_i     = 1'b1;
    tick();
    bus_if.req_i = 1'b0;
    lbad = (bus_if.cpu_rst_o !== 1'b0) ? 1 : 0;
    check("drain_count", 32'(bus_if.rst_count_o), 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_if.cpu_rst_o !== 1'b0) lbad++;
    end
    check("drain_busy", 32'(bus_if.busy_o), 32'd1);
    bus_if.cpu_cyc_i = 1'b0;
    tick();
    if (bus_if.cpu_rst_o !== 1'b0) lbad++;
    check("drain_low_window", 32'(lbad), 32'd0);
    check("drain_mode_frozen", 32'(bus_if.mode_o), 32'(`MODE_RAM));
    wait_release(`MODE_BOOTSTRAP, hi, mbad);
    check("drain_high_len", 32'(hi), 32'(HOLD + SETTLE));
    check("drain_mode_in_reset", 32'(mbad), 32'd0);
    check("drain_no_timeout", 32'(bus_if.drain_to_o), 32'd0);

    // Drain timeout
    bus_if.mode_i    = `MODE_RAM;
    bus_if.cpu_cyc_i = 1'b1;
    bus_if.req_i     = 1'b1;
    tick();
    bus_if.req_i = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (bus_if.cpu_rst_o === 1'b1) break;
    end
    check("timeout_rise_delay", 32'(n), 32'(TO + 1));
    check("timeout_flag", 32'(bus_if.drain_to_o), 32'd1);
    bus_if.cpu_cyc_i = 1'b0;
    wait_release(`MODE_RAM, hi, mbad);
    check("timeout_high_len", 32'(hi), 32'(HOLD + SETTLE));
    check("timeout_flag_sticky", 32'(bus_if.drain_to_o), 32'd1);
    check("timeout_count", 32'(bus_if.rst_count_o), 32'd3);

    // Retrigger in SETTLE with counter at 2
    bus_if.req_i = 1'b1;
    tick();
    bus_if.req_i = 1'b0;
    hi = 0;
    for (int i = 0; i < HOLD + 2; i++) begin
      tick();
      if (bus_if.cpu_rst_o === 1'b1) hi++;
    end
    bus_if.req_i = 1'b1;
    tick();
    bus_if.req_i = 1'b0;
    wait_release(`MODE_RAM, hi2, mbad);
    check("settle_retrig_len", 32'(hi + hi2), 32'(HOLD + 2 + 1 + HOLD + SETTLE));
    check("settle_retrig_count", 32'(bus_if.rst_count_o), 32'd4);

    // Retrigger in HOLD restarts the count
    bus_if.req_i = 1'b1;
    tick();
    bus_if.req_i = 1'b0;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_if.cpu_rst_o === 1'b1) hi++;
    end
    bus_if.req_i = 1'b1;
    tick();
    bus_if.req_i = 1'b0;
    wait_release(`MODE_RAM, hi2, mbad);
    check("hold_retrig_len", 32'(hi + hi2), 32'(5 + 1 + HOLD + SETTLE));
    check("hold_retrig_count", 32'(bus_if.rst_count_o), 32'd5);

    // Saturation
    bad = 0;
    for (int k = 0; k < 260; k++) begin
      bus_if.req_i = 1'b1;
      tick();
      bus_if.req_i = 1'b0;
      wait_release(`MODE_RAM, hi, mbad);
      if (hi != HOLD + SETTLE) bad++;
    end
    check("sat_pulse_lengths", 32'(bad), 32'd0);
    check("sat_count", 32'(bus_if.rst_count_o), 32'd255);

    // wb_rst_i during DRAIN
    bus_if.cpu_cyc_i = 1'b1;
    bus_if.req_i     = 1'b1;
    tick();
    bus_if.req_i = 1'b0;
    repeat (3) tick();
    check("mid_drain_busy", 32'(bus_if.busy_o), 32'd1);
    check("mid_drain_cpu_rst", 32'(bus_if.cpu_rst_o), 32'd0);
    check("mid_drain_flag_sticky", 32'(bus_if.drain_to_o), 32'd1);
    rst = 1'b1;
    bus_if.req_i = 1'b1;
    tick();
    check("wbrst_cpu_rst", 32'(bus_if.cpu_rst_o), 32'd1);
    check("wbrst_busy", 32'(bus_if.busy_o), 32'd1);
    check("wbrst_flag_clr", 32'(bus_if.drain_to_o), 32'd0);
    check("wbrst_count_clr", 32'(bus_if.rst_count_o), 32'd0);
    check("wbrst_mode", 32'(bus_if.mode_o), 32'(`MODE_BOOTSTRAP));
    bus_if.req_i     = 1'b0;
    bus_if.cpu_cyc_i = 1'b0;
    bus_if.mode_i    = `MODE_BOOTLOADER;
    rst = 1'b0;
    tick();
    wait_release(`MODE_BOOTLOADER, hi, mbad);
    check("wbrst_high_len", 32'(hi), 32'(HOLD + SETTLE));
    check("wbrst_mode_in_reset", 32'(mbad), 32'd0);
    check("wbrst_count_after", 32'(bus_if.rst_count_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
